// File: rtl/exc_sequencer.sv
// Exception sequencer / IorD address arbiter for the multicycle MIPS datapath.
// Ports: clk/reset (sync, active-high); exc_* exception pulses; ctrl_iord_sel/ctrl_mem_wr from
//   main control; mem_data_in read data -> iord_sel, mem_wr, epc_wr, pc_wr, pc_value, busy, cause.
// Latency: IDLE passthrough is combinational; exception sequence holds busy for MEM_WAIT+1 cycles.
module exc_sequencer #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [2:0]  ctrl_iord_sel,
  input  logic        ctrl_mem_wr,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  iord_sel,
  output logic        mem_wr,
  output logic        epc_wr,
  output logic        pc_wr,
  output logic [31:0] pc_value,
  output logic        busy,
  output logic [1:0]  cause
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SAVE_EPC = 2'd1,
    S_WAIT     = 2'd2,
    S_LOAD     = 2'd3
  } state_t;

  // Number of WAIT cycles still owed after SAVE_EPC. SAVE_EPC itself is the
  // first cycle the vector address is on the bus, so MEM_WAIT-1 extra cycles
  // put LOAD exactly MEM_WAIT cycles after the address was first presented.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT - 1);

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [2:0] vec_q,   vec_d;
  logic [2:0] cnt_q,   cnt_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cause_q <= 2'b00;
      vec_q   <= 3'b000;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        // Fixed priority: opcode > overflow > div0; losers are dropped.
        if (exc_opcode) begin
          cause_d = 2'b01;
          vec_d   = 3'b010;
          state_d = S_SAVE_EPC;
        end else if (exc_overflow) begin
          cause_d = 2'b10;
          vec_d   = 3'b011;
          state_d = S_SAVE_EPC;
        end else if (exc_div0) begin
          cause_d = 2'b11;
          vec_d   = 3'b100;
          state_d = S_SAVE_EPC;
        end
      end
      S_SAVE_EPC: begin
        cnt_d   = WAIT_INIT;
        state_d = (WAIT_INIT == 3'd0) ? S_LOAD : S_WAIT;
      end
      S_WAIT: begin
        // Leave when the decremented count reaches zero.
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; reset forces the quiescent values rather than passthrough.
  always_comb begin
    iord_sel = 3'b000;
    mem_wr   = 1'b0;
    epc_wr   = 1'b0;
    pc_wr    = 1'b0;
    pc_value = 32'd0;
    busy     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          iord_sel = ctrl_iord_sel;
          mem_wr   = ctrl_mem_wr;
        end
        S_SAVE_EPC: begin
          iord_sel = vec_q;
          epc_wr   = 1'b1;
          busy     = 1'b1;
        end
        S_WAIT: begin
          iord_sel = vec_q;
          busy     = 1'b1;
        end
        S_LOAD: begin
          iord_sel = vec_q;
          pc_wr    = 1'b1;
          pc_value = mem_data_in & 32'h0000_00FF;
          busy     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cause = cause_q;

endmodule
